// File: rtl/dcache_direct_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// State encodings: S_IDLE=0, S_DRAIN=1, S_REFILL=2, S_FILL_DONE=3.
package dcache_direct_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DRAIN     = 2'd1,
        S_REFILL    = 2'd2,
        S_FILL_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/dcache_direct_wbuf.sv
// Store buffer for the data cache: synchronous FIFO with head output,
// async active-low reset on the pointers and occupancy count.
module dcache_wbuf #(
    parameter int DEPTH = 4,
    parameter int W     = 68
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem_q[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= din;
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a store buffer.
// Optional DCACHE_FWD_EN: same-cycle store-to-load forwarding on a read hit.
module dcache_direct
    import dcache_direct_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int INDEX_W    = 8,
    parameter int LINE_WORDS = 4,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_raddr_i,
    input  logic              cpu_rreq_i,
    input  logic [ADDR_W-1:0] cpu_waddr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              cpu_wreq_i,
    input  logic [3:0]        cpu_sel_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_sel_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W - 2;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WB_W  = ADDR_W + 36;

    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];
    logic [SETS-1:0]  valid_q;
    state_t           state_q;
    logic [OFF_W-1:0] cnt_q;
    logic             wr_taken_q;

    logic [TAG_W-1:0]   r_tag, w_tag;
    logic [INDEX_W-1:0] r_idx, w_idx;
    logic [OFF_W-1:0]   r_off, w_off;
    assign r_tag = cpu_raddr_i[ADDR_W-1 -: TAG_W];
    assign r_idx = cpu_raddr_i[OFF_W+2 +: INDEX_W];
    assign r_off = cpu_raddr_i[2 +: OFF_W];
    assign w_tag = cpu_waddr_i[ADDR_W-1 -: TAG_W];
    assign w_idx = cpu_waddr_i[OFF_W+2 +: INDEX_W];
    assign w_off = cpu_waddr_i[2 +: OFF_W];

    logic              rd_hit, wr_hit, wb_full, wb_empty, wb_push, wb_pop;
    logic              drain_ok, stall_raw;
    logic [WB_W-1:0]   wb_head;
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_data, arr_word, rd_word;
    logic [3:0]        head_sel;

    assign {head_addr, head_data, head_sel} = wb_head;

    assign rd_hit   = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign wr_hit   = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign drain_ok = (state_q == S_IDLE) || (state_q == S_DRAIN);
    // A write taken while the read half is still stalled must not be pushed again.
    assign wb_push  = cpu_wreq_i && !wr_taken_q && !wb_full;
    assign wb_pop   = drain_ok && !wb_empty && mem_ack_i;

    assign stall_raw = (cpu_rreq_i && !((state_q == S_IDLE) && rd_hit)) ||
                       (cpu_wreq_i && !wr_taken_q && wb_full);
    assign cpu_stall_o = rst && stall_raw;

    assign arr_word = data_q[r_idx][r_off];
`ifdef DCACHE_FWD_EN
    logic fwd;
    assign fwd     = cpu_rreq_i && cpu_wreq_i && rd_hit &&
                     (cpu_raddr_i[ADDR_W-1:2] == cpu_waddr_i[ADDR_W-1:2]);
    assign rd_word = fwd ? merge_bytes(arr_word, cpu_wdata_i, cpu_sel_i) : arr_word;
`else
    assign rd_word = arr_word;
`endif
    assign cpu_rdata_o = (rst && cpu_rreq_i && !stall_raw) ? rd_word : '0;

    dcache_wbuf #(.DEPTH(WBUF_DEPTH), .W(WB_W)) u_wbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (wb_push),
        .din   ({cpu_waddr_i, cpu_wdata_i, cpu_sel_i}),
        .pop   (wb_pop),
        .head  (wb_head),
        .full  (wb_full),
        .empty (wb_empty)
    );

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_sel_o   = '0;
        if (rst) begin
            if (state_q == S_REFILL) begin
                mem_req_o  = 1'b1;
                mem_addr_o = {r_tag, r_idx, cnt_q, 2'b00};
                mem_sel_o  = 4'hf;
            end else if (drain_ok && !wb_empty) begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {head_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_o = head_data;
                mem_sel_o   = head_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            wr_taken_q <= 1'b0;
        end else begin
            wr_taken_q <= stall_raw && (wr_taken_q || wb_push);
            case (state_q)
                S_IDLE:      if (cpu_rreq_i && !rd_hit) state_q <= S_DRAIN;
                // Refill only once memory holds every accepted store.
                S_DRAIN:     if (wb_empty && !wb_push) begin
                                 state_q <= S_REFILL;
                                 cnt_q   <= '0;
                             end
                S_REFILL:    if (mem_ack_i) begin
                                 cnt_q <= cnt_q + OFF_W'(1);
                                 if (cnt_q == OFF_W'(LINE_WORDS-1)) state_q <= S_FILL_DONE;
                             end
                S_FILL_DONE: begin
                                 valid_q[r_idx] <= 1'b1;
                                 state_q        <= S_IDLE;
                             end
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_REFILL && mem_ack_i) data_q[r_idx][cnt_q] <= mem_rdata_i;
        if (state_q == S_FILL_DONE)           tag_q[r_idx] <= r_tag;
        if (wb_push && wr_hit)
            data_q[w_idx][w_off] <= merge_bytes(data_q[w_idx][w_off], cpu_wdata_i, cpu_sel_i);
    end

    logic unused_bits;
    assign unused_bits = ^{cpu_raddr_i[1:0], cpu_waddr_i[1:0], head_addr[1:0]};

endmodule

// File: tb/tb_dcache_direct.sv
// Bench for dcache_direct: directed scenarios plus randomized traffic checked against
// a flat memory image and a set->tag residency map.
module tb_dcache_direct;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cpu_raddr_i = '0, cpu_waddr_i = '0, cpu_wdata_i = '0;
    logic        cpu_rreq_i = 1'b0, cpu_wreq_i = 1'b0;
    logic [3:0]  cpu_sel_i = '0;
    logic [31:0] cpu_rdata_o, mem_addr_o, mem_wdata_o;
    logic        cpu_stall_o, mem_req_o, mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;

    dcache_direct dut (
        .clk(clk), .rst(rst),
        .cpu_raddr_i(cpu_raddr_i), .cpu_rreq_i(cpu_rreq_i),
        .cpu_waddr_i(cpu_waddr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_wreq_i(cpu_wreq_i),
        .cpu_sel_i(cpu_sel_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    int n_checks = 0, n_pass = 0;
    bit ack_en = 1'b1;
    int lat = 0, wait_cnt = 0;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; logic [3:0] sel; } mtx_t;
    mtx_t mlog[$];
    logic [31:0] backing [int unsigned];   // memory device contents
    logic [31:0] view    [int unsigned];   // what the CPU should observe
    logic [19:0] resident [int];           // set index -> resident tag

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    function automatic logic [31:0] wkey(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
    function automatic logic [31:0] rd_back(input logic [31:0] a);
        return backing.exists(wkey(a)) ? backing[wkey(a)] : init_word(wkey(a));
    endfunction
    function automatic logic [31:0] vw(input logic [31:0] a);
        return view.exists(wkey(a)) ? view[wkey(a)] : init_word(wkey(a));
    endfunction
    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction
    function automatic bit predict_hit(input logic [31:0] a);
        return resident.exists(int'(a[11:4])) && resident[int'(a[11:4])] == a[31:12];
    endfunction

    // Memory device: acks after `lat` idle cycles, applies writes at the ack.
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (!rst || !mem_req_o || !ack_en) wait_cnt = 0;
        else if (wait_cnt >= lat) begin
            mem_ack_i = 1'b1;
            wait_cnt = 0;
            mlog.push_back('{mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o});
            if (mem_we_o) backing[wkey(mem_addr_o)] = mrg(rd_back(mem_addr_o), mem_wdata_o, mem_sel_o);
            else mem_rdata_i = rd_back(mem_addr_o);
        end else wait_cnt++;
    end

    task automatic do_access(input bit rd, input logic [31:0] ra, input bit wr,
                             input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] sel,
                             output logic [31:0] rdat, output int stalls);
        cpu_rreq_i = rd; cpu_raddr_i = ra; cpu_wreq_i = wr;
        cpu_waddr_i = wa; cpu_wdata_i = wd; cpu_sel_i = sel;
        stalls = 0; rdat = '0;
        forever begin
            @(negedge clk);
            if (!cpu_stall_o) begin rdat = cpu_rdata_o; break; end
            stalls++;
            if (stalls > 300) begin
                n_checks++;
                $display("FAIL access_timeout: stall=1 after %0d cycles, need 0", stalls);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_rreq_i = 1'b0; cpu_wreq_i = 1'b0;
    endtask

    task automatic wait_idle;
        int quiet = 0, n = 0;
        while (quiet < 3 && n < 500) begin
            @(negedge clk); n++;
            if (mem_req_o) quiet = 0; else quiet++;
        end
        n_checks++;
        if (quiet < 3) $display("FAIL wait_idle: mem_req_o busy after %0d cycles, need idle", n);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset;
        cpu_rreq_i = 1'b0; cpu_wreq_i = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        resident.delete();
    endtask

    task automatic cpu_read(input logic [31:0] a, input string nm);
        logic [31:0] d; int st; bit hit; logic [31:0] exp;
        hit = predict_hit(a); exp = vw(a);
        do_access(1, a, 0, 0, 0, 0, d, st);
        if (!hit) resident[int'(a[11:4])] = a[31:12];
        n_checks++;
        if (d !== exp || (st == 0) !== hit)
            $display("FAIL %s: rdata=%h stalls=%0d, need rdata=%h hit=%0d", nm, d, st, exp, hit);
        else n_pass++;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] d; int st;
        do_access(0, 0, 1, a, wd, s, d, st);
        view[wkey(a)] = mrg(vw(a), wd, s);
    endtask

    task automatic test_reset;
        cpu_rreq_i = 1'b1; cpu_wreq_i = 1'b1; cpu_sel_i = 4'hf; cpu_wdata_i = 32'hFFFF_FFFF;
        #2;
        n_checks++;
        if (cpu_stall_o !== 1'b0 || cpu_rdata_o !== 32'h0)
            $display("FAIL reset_cpu_out: stall=%b rdata=%h, need 0/0", cpu_stall_o, cpu_rdata_o);
        else n_pass++;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o} !== '0)
            $display("FAIL reset_mem_out: req=%b we=%b addr=%h, need all 0", mem_req_o, mem_we_o, mem_addr_o);
        else n_pass++;
        cpu_rreq_i = 1'b0; cpu_wreq_i = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_stall_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL reset_idle: stall=%b req=%b, need 0/0", cpu_stall_o, mem_req_o);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss;
        logic [31:0] d; int st;
        wait_idle(); mlog.delete();
        cpu_write(32'h10, 32'h0000_1234, 4'hf);
        do_access(1, 32'h10, 0, 0, 0, 0, d, st);
        resident[1] = 20'h0;
        n_checks++;
        if (st == 0 || d !== 32'h1234) $display("FAIL t1_miss: rdata=%h stalls=%0d, need 00001234 stalls>0", d, st);
        else n_pass++;
        n_checks++;
        if (mlog.size() != 5) $display("FAIL t1_mem_count: %0d transfers, need 5", mlog.size());
        else begin
            bit ok;
            ok = mlog[0].we && mlog[0].addr == 32'h10 && mlog[0].data == 32'h1234 && mlog[0].sel == 4'hf;
            for (int i = 1; i < 5; i++) ok &= !mlog[i].we && mlog[i].addr == 32'h10 + 4*(i-1);
            if (!ok) $display("FAIL t1_mem_order: first=%h we=%b, need write 10 then reads 10..1c", mlog[0].addr, mlog[0].we);
            else n_pass++;
        end
        cpu_read(32'h10, "t1_rehit");
    endtask

    task automatic test_partial_write;
        logic [31:0] d; int st;
        cpu_read(32'h20, "t2_fill");
        wait_idle(); mlog.delete();
        cpu_write(32'h20, 32'h0000_00AA, 4'b0001);
        wait_idle();
        n_checks++;
        if (mlog.size() != 1 || mlog[0].sel !== 4'b0001 || mlog[0].data[7:0] !== 8'hAA)
            $display("FAIL t2_mem_sel: n=%0d sel=%b, need 1 write sel=0001", mlog.size(), mlog.size() ? mlog[0].sel : 4'hx);
        else n_pass++;
        do_access(1, 32'h20, 0, 0, 0, 0, d, st);
        n_checks++;
        if (st != 0 || d !== {init_word(32'h20) >> 8, 8'hAA} && d !== vw(32'h20) || d[7:0] !== 8'hAA || d !== vw(32'h20))
            $display("FAIL t2_merge: rdata=%h stalls=%0d, need %h hit", d, st, vw(32'h20));
        else n_pass++;
    endtask

    task automatic test_wbuf_full;
        logic [31:0] d; int st, n; bit ok;
        logic [31:0] dat [5];
        wait_idle(); ack_en = 1'b0; mlog.delete();
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat[i] = $urandom;
            do_access(0, 0, 1, 32'h100 + 4*i, dat[i], 4'hf, d, st);
            view[32'h100 + 4*i] = dat[i];
            ok &= (st == 0);
        end
        n_checks++;
        if (!ok) $display("FAIL t3_first4: a write stalled, need 4 accepted without stall");
        else n_pass++;
        dat[4] = $urandom;
        cpu_wreq_i = 1'b1; cpu_waddr_i = 32'h110; cpu_wdata_i = dat[4]; cpu_sel_i = 4'hf;
        ok = 1'b1;
        repeat (3) begin @(negedge clk); ok &= (cpu_stall_o === 1'b1); end
        n_checks++;
        if (!ok) $display("FAIL t3_full_stall: stall=%b while full, need 1", cpu_stall_o);
        else n_pass++;
        ack_en = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (cpu_stall_o && n < 50);
        n_checks++;
        if (cpu_stall_o !== 1'b0) $display("FAIL t3_accept: stall=%b after ack, need 0", cpu_stall_o);
        else n_pass++;
        @(posedge clk); #1 cpu_wreq_i = 1'b0;
        view[32'h110] = dat[4];
        wait_idle();
        ok = (mlog.size() == 5);
        for (int i = 0; i < 5 && ok; i++) ok &= mlog[i].we && mlog[i].addr == 32'h100 + 4*i && mlog[i].data == dat[i];
        n_checks++;
        if (!ok) $display("FAIL t3_order: %0d writes seen, need 5 in order 100..110", mlog.size());
        else n_pass++;
    endtask

    task automatic test_evict;
        wait_idle(); apply_reset();
        cpu_read(32'h010, "t4_miss_a");
        cpu_read(32'h1010, "t4_miss_b");
        cpu_read(32'h010, "t4_evicted");
    endtask

    task automatic test_reset_refill;
        int n = 0, reads;
        wait_idle(); mlog.delete();
        cpu_rreq_i = 1'b1; cpu_raddr_i = 32'h50;
        do begin
            @(negedge clk); #2; n++;
            reads = 0;
            foreach (mlog[i]) if (!mlog[i].we) reads++;
        end while (reads < 3 && n < 100);
        rst = 1'b0; #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0 || cpu_rdata_o !== 32'h0)
            $display("FAIL t5_async_rst: req=%b stall=%b rdata=%h reads=%0d, need 0/0/0 reads=3", mem_req_o, cpu_stall_o, cpu_rdata_o, reads);
        else n_pass++;
        cpu_rreq_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        resident.delete();
        cpu_read(32'h10, "t5_after_rst");
    endtask

    task automatic test_same_cycle;
        logic [31:0] d, old, exp; int st;
        logic [31:0] wds [2] = '{32'h0000_BEEF, 32'h1234_5678};
        logic [3:0]  sels[2] = '{4'hf, 4'b0011};
        logic [31:0] adr [2] = '{32'h30, 32'h34};
        cpu_read(32'h30, "t6_fill");
        for (int i = 0; i < 2; i++) begin
            old = vw(adr[i]);
            do_access(1, adr[i], 1, adr[i], wds[i], sels[i], d, st);
`ifdef DCACHE_FWD_EN
            exp = mrg(old, wds[i], sels[i]);
`else
            exp = old;
`endif
            view[adr[i]] = mrg(old, wds[i], sels[i]);
            n_checks++;
            if (d !== exp || st != 0) $display("FAIL t6_same_cycle%0d: rdata=%h stalls=%0d, need %h hit", i, d, st, exp);
            else n_pass++;
            cpu_read(adr[i], "t6_after");
        end
    endtask

    task automatic test_random;
        logic [31:0] ra, wa, wd, d, pre, exp; logic [3:0] s; int st, op, bad; bit hit;
        for (int k = 0; k < 300; k++) begin
            lat = $urandom_range(0, 2);
            op  = $urandom_range(0, 2);
            ra  = ($urandom_range(0, 2) << 12) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            wa  = ($urandom_range(0, 2) << 12) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) wa = ra;
            wd = $urandom; s = 4'($urandom_range(1, 15));
            hit = predict_hit(ra); pre = vw(ra);
            do_access(op != 1, ra, op != 0, wa, wd, s, d, st);
            if (op != 0) view[wkey(wa)] = mrg(vw(wa), wd, s);
            if (op == 1) continue;
            if (!hit) resident[int'(ra[11:4])] = ra[31:12];
            exp = hit ? pre : vw(ra);
`ifdef DCACHE_FWD_EN
            if (hit && op == 2 && wkey(ra) == wkey(wa)) exp = mrg(pre, wd, s);
`endif
            n_checks++;
            if (d !== exp || (op == 0 && (st == 0) !== hit))
                $display("FAIL rand%0d: op=%0d ra=%h rdata=%h stalls=%0d, need %h hit=%0d", k, op, ra, d, st, exp, hit);
            else n_pass++;
        end
        lat = 0;
        wait_idle();
        bad = 0;
        foreach (view[a]) if (rd_back(a) !== view[a]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL mem_coherent: %0d words differ from stores, need 0", bad);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, need $finish earlier");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_miss();
        test_partial_write();
        test_wbuf_full();
        test_evict();
        test_reset_refill();
        test_same_cycle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
